audio_playback_sequencer: RTL

Sequences playback of 8-bit PCM audio from the shared 32-bit sample ROM (4 samples per word, byte 0 first) under CPU command control. Takes PLAY/PAUSE/STOP commands with start/end word addresses and a loop flag. Drives the ROM read port with a one-word prefetch and emits one sample per sample period to the PWM stage. Sits between the CPU MMIO command register and the PWM modulator, and owns the ROM address port.

---
 rtl/audio_playback_sequencer_pkg.sv | 30 +++
 rtl/audio_playback_sequencer_if.sv | 27 ++
 rtl/audio_playback_sequencer_timer.sv | 27 ++
 rtl/audio_playback_sequencer.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/audio_playback_sequencer_pkg.sv
// Shared types and constants for the audio playback sequencer.
// vol_scale is only used when the design is built with VOLUME_EN defined.
package audio_pkg;

  typedef enum logic [1:0] {
    CMD_NOP   = 2'b00,
    CMD_PLAY  = 2'b01,
    CMD_PAUSE = 2'b10,
    CMD_STOP  = 2'b11
  } cmd_op_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PRIME = 3'd1,
    ST_PLAY  = 3'd2,
    ST_PAUSE = 3'd3
  } state_e;

  localparam logic [7:0] SILENCE = 8'h80;
  localparam int SAMPLES_PER_WORD = 4;

  // Attenuate around the 0x80 midpoint so that silence maps to silence.
  function automatic logic [7:0] vol_scale(input logic [7:0] raw, input logic [2:0] vol);
    logic signed [8:0] centered;
    centered = $signed({1'b0, raw}) - 9'sd128;
    centered = centered >>> vol;
    return 8'(centered + 9'sd128);
  endfunction

endpackage

// File: rtl/audio_playback_sequencer_if.sv
// Command channel from the CPU plus the sample ROM read port.
// The slave modport is the sequencer's view; master is the CPU/ROM side.
interface audio_playback_sequencer_if
  import audio_pkg::*;
#(
  parameter int ADDR_W = 18
) ();
  logic              cmd_valid;
  logic              cmd_ready;
  cmd_op_e           cmd_op;
  logic [ADDR_W-1:0] start_addr;
  logic [ADDR_W-1:0] end_addr;
  logic              loop_en;
  logic              rom_en;
  logic [ADDR_W-1:0] rom_addr;
  logic [31:0]       rom_data;

  modport slave (
    input  cmd_valid, cmd_op, start_addr, end_addr, loop_en, rom_data,
    output cmd_ready, rom_en, rom_addr
  );

  modport master (
    output cmd_valid, cmd_op, start_addr, end_addr, loop_en, rom_data,
    input  cmd_ready, rom_en, rom_addr
  );
endinterface

// File: rtl/audio_playback_sequencer_timer.sv
// Sample-period divider: counts while enabled, holds when frozen, clears synchronously.
// tick is high during the last clock of each sample period.
module audio_sample_timer #(
  parameter int DIVIDER = 12500
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic tick
);
  localparam int CNT_W = (DIVIDER > 1) ? $clog2(DIVIDER) : 1;

  logic [CNT_W-1:0] cnt_reg;

  assign tick = en && (cnt_reg == CNT_W'(DIVIDER - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_reg <= '0;
    end else if (clr) begin
      cnt_reg <= '0;
    end else if (en) begin
      cnt_reg <= tick ? '0 : cnt_reg + CNT_W'(1);
    end
  end
endmodule

// File: rtl/audio_playback_sequencer.sv
// Plays 8-bit PCM from the 32-bit sample ROM with a one-word prefetch, one sample per period.
// Build with VOLUME_EN defined to add the volume input (arithmetic attenuation around 0x80).
module audio_playback_sequencer
  import audio_pkg::*;
#(
  parameter int CLK_FREQ    = 100_000_000,
  parameter int SAMPLE_RATE = 8000,
  parameter int ADDR_W      = 18
) (
  input  logic                        clk,
  input  logic                        reset,
`ifdef VOLUME_EN
  input  logic [2:0]                  volume,
`endif
  audio_playback_sequencer_if.slave   bus,
  output logic [7:0]                  sample,
  output logic                        sample_valid,
  output logic                        busy,
  output logic                        done,
  output logic                        cmd_err,
  output logic [2:0]                  state
);
  localparam int DIVIDER = CLK_FREQ / SAMPLE_RATE;

  generate
    if (DIVIDER < 8) begin : g_bad_divider
      $error("audio_playback_sequencer: CLK_FREQ/SAMPLE_RATE must be at least 8");
    end
  endgenerate

  state_e            state_reg, state_next;
  logic [ADDR_W-1:0] start_reg, start_next, last_reg, last_next, addr_reg, addr_next;
  logic              loop_reg, loop_next;
  logic [31:0]       cur_word_reg, cur_word_next, next_word_reg, next_word_next;
  logic              next_vld_reg, next_vld_next;
  logic [1:0]        phase_reg, phase_next;
  logic [7:0]        sample_reg, sample_next;
  logic              sample_valid_reg, sample_valid_next;
  logic              done_reg, done_next, cmd_err_reg, cmd_err_next;
  logic              rom_en_reg, rom_en_next, rd_vld_reg, rd_vld_next;
  logic [ADDR_W-1:0] rom_addr_reg, rom_addr_next;

  logic              tick, timer_en, timer_clr;
  logic [7:0]        word_bytes [SAMPLES_PER_WORD];
  logic [7:0]        raw_byte, shaped_byte;
  logic [ADDR_W-1:0] addr_succ, addr_succ2;
  logic              accept, play_cmd, pause_cmd, stop_cmd;

  function automatic logic [ADDR_W-1:0] step_addr(input logic [ADDR_W-1:0] a, s, e);
    return (a == e) ? s : a + ADDR_W'(1);
  endfunction

  function automatic logic more_words(input logic [ADDR_W-1:0] a, e, input logic lp);
    return (a != e) || lp;
  endfunction

  generate
    for (genvar gi = 0; gi < SAMPLES_PER_WORD; gi++) begin : g_bytes
      assign word_bytes[gi] = cur_word_reg[gi*8 +: 8];
    end
  endgenerate

  assign raw_byte = word_bytes[phase_reg];
`ifdef VOLUME_EN
  assign shaped_byte = vol_scale(raw_byte, volume);
`else
  assign shaped_byte = raw_byte;
`endif

  assign addr_succ  = step_addr(addr_reg, start_reg, last_reg);
  assign addr_succ2 = step_addr(addr_succ, start_reg, last_reg);

  assign timer_en  = (state_reg == ST_PLAY);
  assign timer_clr = (state_reg == ST_IDLE) || (state_reg == ST_PRIME);

  audio_sample_timer #(.DIVIDER(DIVIDER)) u_timer (
    .clk   (clk),
    .reset (reset),
    .en    (timer_en),
    .clr   (timer_clr),
    .tick  (tick)
  );

  assign accept    = bus.cmd_valid && bus.cmd_ready;
  assign play_cmd  = accept && (bus.cmd_op == CMD_PLAY);
  assign pause_cmd = accept && (bus.cmd_op == CMD_PAUSE);
  // STOP must be able to abort PRIME, where cmd_ready is low, so it bypasses the handshake.
  assign stop_cmd  = bus.cmd_valid && (bus.cmd_op == CMD_STOP);

  always_comb begin
    state_next        = state_reg;
    start_next        = start_reg;
    last_next         = last_reg;
    loop_next         = loop_reg;
    addr_next         = addr_reg;
    cur_word_next     = cur_word_reg;
    next_word_next    = next_word_reg;
    next_vld_next     = next_vld_reg;
    phase_next        = phase_reg;
    sample_next       = sample_reg;
    sample_valid_next = 1'b0;
    done_next         = 1'b0;
    cmd_err_next      = 1'b0;
    rom_en_next       = 1'b0;
    rom_addr_next     = rom_addr_reg;
    rd_vld_next       = rom_en_reg;

    case (state_reg)
      ST_IDLE: begin
        sample_next = SILENCE;
        phase_next  = 2'd0;
        if (play_cmd) begin
          if (bus.start_addr > bus.end_addr) begin
            cmd_err_next = 1'b1;
          end else begin
            start_next    = bus.start_addr;
            last_next     = bus.end_addr;
            loop_next     = bus.loop_en;
            addr_next     = bus.start_addr;
            rom_en_next   = 1'b1;
            rom_addr_next = bus.start_addr;
            state_next    = ST_PRIME;
          end
        end
      end
      ST_PRIME: begin
        if (rd_vld_reg) begin
          cur_word_next = bus.rom_data;
          next_vld_next = 1'b0;
          phase_next    = 2'd0;
          state_next    = ST_PLAY;
          if (more_words(addr_reg, last_reg, loop_reg)) begin
            rom_en_next   = 1'b1;
            rom_addr_next = addr_succ;
          end
        end
      end
      ST_PLAY, ST_PAUSE: begin
        if (rd_vld_reg) begin
          next_word_next = bus.rom_data;
          next_vld_next  = 1'b1;
        end
        if (state_reg == ST_PLAY && pause_cmd) state_next = ST_PAUSE;
        if (state_reg == ST_PAUSE && play_cmd) state_next = ST_PLAY;
        if (tick) begin
          sample_next       = shaped_byte;
          sample_valid_next = 1'b1;
          phase_next        = phase_reg + 2'd1;
          if (phase_reg == 2'(SAMPLES_PER_WORD - 1)) begin
            if (!more_words(addr_reg, last_reg, loop_reg)) begin
              state_next = ST_IDLE;
              done_next  = 1'b1;
            end else begin
              // A missing prefetch plays out as silence rather than stale data.
              cur_word_next = next_vld_reg ? next_word_reg : {SAMPLES_PER_WORD{SILENCE}};
              next_vld_next = 1'b0;
              addr_next     = addr_succ;
              if (more_words(addr_succ, last_reg, loop_reg)) begin
                rom_en_next   = 1'b1;
                rom_addr_next = addr_succ2;
              end
            end
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase

    if (stop_cmd) begin
      state_next        = ST_IDLE;
      sample_next       = SILENCE;
      sample_valid_next = 1'b0;
      done_next         = 1'b0;
      next_vld_next     = 1'b0;
      rd_vld_next       = 1'b0;
      rom_en_next       = 1'b0;
      phase_next        = 2'd0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg        <= ST_IDLE;
      start_reg        <= '0;
      last_reg         <= '0;
      loop_reg         <= 1'b0;
      addr_reg         <= '0;
      cur_word_reg     <= '0;
      next_word_reg    <= '0;
      next_vld_reg     <= 1'b0;
      phase_reg        <= 2'd0;
      sample_reg       <= SILENCE;
      sample_valid_reg <= 1'b0;
      done_reg         <= 1'b0;
      cmd_err_reg      <= 1'b0;
      rom_en_reg       <= 1'b0;
      rom_addr_reg     <= '0;
      rd_vld_reg       <= 1'b0;
    end else begin
      state_reg        <= state_next;
      start_reg        <= start_next;
      last_reg         <= last_next;
      loop_reg         <= loop_next;
      addr_reg         <= addr_next;
      cur_word_reg     <= cur_word_next;
      next_word_reg    <= next_word_next;
      next_vld_reg     <= next_vld_next;
      phase_reg        <= phase_next;
      sample_reg       <= sample_next;
      sample_valid_reg <= sample_valid_next;
      done_reg         <= done_next;
      cmd_err_reg      <= cmd_err_next;
      rom_en_reg       <= rom_en_next;
      rom_addr_reg     <= rom_addr_next;
      rd_vld_reg       <= rd_vld_next;
    end
  end

  assign bus.cmd_ready = (state_reg != ST_PRIME);
  assign bus.rom_en    = rom_en_reg;
  assign bus.rom_addr  = rom_addr_reg;
  assign sample        = sample_reg;
  assign sample_valid  = sample_valid_reg;
  assign busy          = (state_reg != ST_IDLE);
  assign done          = done_reg;
  assign cmd_err       = cmd_err_reg;
  assign state         = state_reg;
endmodule
